aes_decrypt_controller: RTL and testbench

Sequencing FSM for the AES-128 decryption core behind the Avalon-MM register interface. It watches the START register bit. It then runs key expansion wait, the initial AddRoundKey, nine full inverse rounds and the final inverse round over the shared state-register datapath. It issues the load, operation-select, round-key-index and column-index controls, and finishes with a START/DONE level handshake back to the register file.

---
 rtl/aes_decrypt_controller_if.sv | 22 ++
 rtl/aes_decrypt_controller.sv | 159 +++++++++++++++
 tb/tb_aes_decrypt_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_decrypt_controller_if.sv
// rtl/aes_decrypt_controller_if.sv - START/DONE handshake and datapath control bundle for the AES-128 decrypt sequencer
interface aes_decrypt_controller_if;
  logic       AES_START;
  logic       AES_DONE;
  logic       BUSY;
  logic       LD_MSG;
  logic       LD_STATE;
  logic [2:0] OP_SEL;
  logic [3:0] RK_IDX;
  logic [1:0] MC_WORD;
  logic       LD_RESULT;

  modport master (
    input  AES_START,
    output AES_DONE, BUSY, LD_MSG, LD_STATE, OP_SEL, RK_IDX, MC_WORD, LD_RESULT
  );

  modport slave (
    output AES_START,
    input  AES_DONE, BUSY, LD_MSG, LD_STATE, OP_SEL, RK_IDX, MC_WORD, LD_RESULT
  );
endinterface

// File: rtl/aes_decrypt_controller.sv
// rtl/aes_decrypt_controller.sv - AES-128 inverse-cipher sequencer driving the shared state-register datapath
module aes_decrypt_controller #(
  parameter int unsigned KEYEXP_CYCLES = 12
) (
  input  logic                    CLK,
  input  logic                    RESET,
  aes_decrypt_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_KEYEXP, S_INIT_ARK, S_ISR, S_ISB, S_ARK, S_IMC,
    S_F_ISR, S_F_ISB, S_F_ARK, S_WRITEBACK, S_DONE
  } state_e;

  localparam logic [7:0] KEXP_LOAD = 8'(KEYEXP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] col_q, col_d;

  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ld_msg_q, ld_msg_d;
  logic       ld_state_q, ld_state_d;
  logic       ld_result_q, ld_result_d;
  logic [2:0] op_sel_q, op_sel_d;
  logic [3:0] rk_idx_q, rk_idx_d;
  logic [1:0] mc_word_q, mc_word_d;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    wait_d  = wait_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE:      if (bus.AES_START) state_d = S_LOAD;
      S_LOAD: begin
        wait_d  = KEXP_LOAD;
        rnd_d   = 4'd10;
        state_d = S_KEYEXP;
      end
      S_KEYEXP: begin
        if (wait_q == 8'd0) state_d = S_INIT_ARK;
        else                wait_d  = wait_q - 8'd1;
      end
      S_INIT_ARK: begin
        rnd_d   = 4'd9;
        state_d = S_ISR;
      end
      S_ISR:       state_d = S_ISB;
      S_ISB:       state_d = S_ARK;
      S_ARK:       state_d = S_IMC;
      // Column counter only wraps when leaving IMC, so it is always 0 on IMC entry.
      S_IMC: begin
        if (col_q == 2'd3) begin
          col_d = 2'd0;
          if (rnd_q == 4'd1) begin
            state_d = S_F_ISR;
          end else begin
            rnd_d   = rnd_q - 4'd1;
            state_d = S_ISR;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      S_F_ISR:     state_d = S_F_ISB;
      S_F_ISB:     state_d = S_F_ARK;
      S_F_ARK:     state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_DONE;
      S_DONE:      if (!bus.AES_START) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    ld_msg_d    = (state_d == S_LOAD);
    ld_result_d = (state_d == S_WRITEBACK);
    ld_state_d  = 1'b0;
    op_sel_d    = 3'd0;
    mc_word_d   = 2'd0;
    rk_idx_d    = rnd_d;
    case (state_d)
      S_IDLE:           rk_idx_d = 4'd0;
      S_INIT_ARK: begin
        ld_state_d = 1'b1;
        op_sel_d   = 3'd1;
        rk_idx_d   = 4'd10;
      end
      S_ISR, S_F_ISR: begin
        ld_state_d = 1'b1;
        op_sel_d   = 3'd2;
      end
      S_ISB, S_F_ISB: begin
        ld_state_d = 1'b1;
        op_sel_d   = 3'd3;
      end
      S_ARK: begin
        ld_state_d = 1'b1;
        op_sel_d   = 3'd1;
      end
      S_IMC: begin
        ld_state_d = 1'b1;
        op_sel_d   = 3'd4;
        mc_word_d  = col_d;
      end
      S_F_ARK: begin
        ld_state_d = 1'b1;
        op_sel_d   = 3'd1;
        rk_idx_d   = 4'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      rnd_q       <= 4'd0;
      wait_q      <= 8'd0;
      col_q       <= 2'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ld_msg_q    <= 1'b0;
      ld_state_q  <= 1'b0;
      ld_result_q <= 1'b0;
      op_sel_q    <= 3'd0;
      rk_idx_q    <= 4'd0;
      mc_word_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      wait_q      <= wait_d;
      col_q       <= col_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ld_msg_q    <= ld_msg_d;
      ld_state_q  <= ld_state_d;
      ld_result_q <= ld_result_d;
      op_sel_q    <= op_sel_d;
      rk_idx_q    <= rk_idx_d;
      mc_word_q   <= mc_word_d;
    end
  end

  assign bus.AES_DONE  = done_q;
  assign bus.BUSY      = busy_q;
  assign bus.LD_MSG    = ld_msg_q;
  assign bus.LD_STATE  = ld_state_q;
  assign bus.LD_RESULT = ld_result_q;
  assign bus.OP_SEL    = op_sel_q;
  assign bus.RK_IDX    = rk_idx_q;
  assign bus.MC_WORD   = mc_word_q;

endmodule

// File: tb/tb_aes_decrypt_controller.sv
// tb/tb_aes_decrypt_controller.sv - scoreboard bench for the AES decrypt sequencer
module tb_aes_decrypt_controller;
  localparam int KEXP = 12;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  aes_decrypt_controller_if bus_if();

  aes_decrypt_controller #(.KEYEXP_CYCLES(KEXP)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus_if)
  );

  always #5 CLK = ~CLK;

  // {done, busy, ld_msg, ld_state, ld_result, op_sel[2:0], rk_idx[3:0], mc_word[1:0]}
  typedef logic [13:0] vec_t;
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;

  vec_t    exp_q[$];
  vec_t    run_q[$];
  mphase_e mphase   = M_IDLE;
  int      last_rnd = 0;
  int      vectors  = 0;
  int      miscompares = 0;
  int      runs_done = 0;

  function automatic vec_t mk(bit done, bit busy, bit msg, bit st, bit res, int op, int rk, int mc);
    return {done, busy, msg, st, res, 3'(op), 4'(rk), 2'(mc)};
  endfunction

  function automatic vec_t got();
    return {bus_if.AES_DONE, bus_if.BUSY, bus_if.LD_MSG, bus_if.LD_STATE, bus_if.LD_RESULT,
            bus_if.OP_SEL, bus_if.RK_IDX, bus_if.MC_WORD};
  endfunction

  // Expected per-cycle control trace for one full decryption, written out from the round schedule.
  function automatic void build_run();
    run_q.delete();
    run_q.push_back(mk(0, 1, 1, 0, 0, 0, last_rnd, 0));
    for (int k = 0; k < KEXP; k++) run_q.push_back(mk(0, 1, 0, 0, 0, 0, 10, 0));
    run_q.push_back(mk(0, 1, 0, 1, 0, 1, 10, 0));
    for (int r = 9; r >= 1; r--) begin
      run_q.push_back(mk(0, 1, 0, 1, 0, 2, r, 0));
      run_q.push_back(mk(0, 1, 0, 1, 0, 3, r, 0));
      run_q.push_back(mk(0, 1, 0, 1, 0, 1, r, 0));
      for (int c = 0; c < 4; c++) run_q.push_back(mk(0, 1, 0, 1, 0, 4, r, c));
    end
    run_q.push_back(mk(0, 1, 0, 1, 0, 2, 1, 0));
    run_q.push_back(mk(0, 1, 0, 1, 0, 3, 1, 0));
    run_q.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0));
    run_q.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
  endfunction

  function automatic vec_t model_step(bit s);
    vec_t e;
    case (mphase)
      M_IDLE: begin
        if (s) begin
          build_run();
          e = run_q.pop_front();
          mphase = M_RUN;
        end else begin
          e = '0;
        end
      end
      M_RUN: begin
        if (run_q.size() > 0) begin
          e = run_q.pop_front();
        end else begin
          last_rnd = 1;
          e = mk(1, 0, 0, 0, 0, 0, last_rnd, 0);
          mphase = M_DONE;
        end
      end
      default: begin
        if (s) e = mk(1, 0, 0, 0, 0, 0, last_rnd, 0);
        else begin
          e = '0;
          mphase = M_IDLE;
        end
      end
    endcase
    return e;
  endfunction

  function automatic void model_reset();
    mphase   = M_IDLE;
    last_rnd = 0;
    run_q.delete();
  endfunction

  task automatic check(input string name, input vec_t g, input vec_t e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b_%b_%b%b%b_%0d_%0d_%0d expected %b_%b_%b%b%b_%0d_%0d_%0d",
               name, $time, g[13], g[12], g[11], g[10], g[9], g[8:6], g[5:2], g[1:0],
               e[13], e[12], e[11], e[10], e[9], e[8:6], e[5:2], e[1:0]);
    end
  endtask

  task automatic check_int(input string name, input int g, input int e);
    vectors++;
    if (g != e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, g, e);
    end
  endtask

  // One stimulus cycle: drive inputs at the falling edge and queue what the next rising edge must show.
  task automatic tick(input bit s, input bit rst_low);
    @(negedge CLK);
    bus_if.AES_START = s;
    if (rst_low) begin
      RESET = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check("reset_async", got(), '0);
      exp_q.push_back('0);
    end else begin
      RESET = 1'b1;
      exp_q.push_back(model_step(s));
    end
  endtask

  initial begin : monitor
    int   cyc = 0;
    int   t0 = 0;
    int   nst = 0;
    bit   armed = 0;
    bit   prev_done = 0;
    vec_t g;
    vec_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      g = got();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("trace", g, e);
      end
      vectors++;
      if (int'(g[11]) + int'(g[10]) + int'(g[9]) > 1) begin
        miscompares++;
        $display("FAIL load_onehot at %0t: got msg=%0d state=%0d result=%0d expected at most one",
                 $time, g[11], g[10], g[9]);
      end
      if (!RESET) begin
        armed = 0;
      end else begin
        if (g[11]) begin
          armed = 1;
          t0    = cyc;
          nst   = 0;
        end
        if (g[10]) nst++;
        if (g[13] && !prev_done && armed) begin
          check_int("latency", cyc - t0, KEXP + 69);
          check_int("ld_state_cycles", nst, 67);
          armed = 0;
          runs_done++;
        end
      end
      prev_done = g[13];
    end
  end

  initial begin : stimulus
    bus_if.AES_START = 1'b0;
    model_reset();
    repeat (3) tick(0, 1);
    repeat (20) tick(0, 0);

    repeat (KEXP + 69 + $urandom_range(1, 15)) tick(1, 0);
    repeat ($urandom_range(2, 6)) tick(0, 0);

    repeat (3) tick(1, 0);
    repeat (95) tick(0, 0);

    repeat (40) tick(1, 0);
    repeat ($urandom_range(1, 3)) tick(1, 1);
    repeat (100) tick(1, 0);
    repeat (3) tick(0, 0);

    repeat (KEXP + 69 + 10) tick(1, 0);
    tick(0, 0);
    repeat (KEXP + 69 + 5) tick(1, 0);
    repeat (3) tick(0, 0);

    for (int i = 0; i < 14; i++) begin
      bit s;
      int n;
      s = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 110);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick(s, 1);
      repeat (n) tick(s, 0);
    end
    repeat (3) tick(0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
    #2;
    check_int("scoreboard_drained", exp_q.size(), 0);
    vectors++;
    if (runs_done < 5) begin
      miscompares++;
      $display("FAIL runs_completed: got %0d expected at least 5", runs_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
